pcf8591_scan_ctrl: RTL and testbench

- Parametrised multi-channel I2C master for the PCF8591 ADC; successor to the single-channel fixed-timing reader.
- Periodically scans NUM_CH analog inputs using the device's auto-increment mode.
- Publishes per-channel 8-bit results with valid strobes, and flags slave NACKs.
- Sits between the board I2C pins and display/processing logic.

---
 rtl/pcf8591_scan_ctrl_pkg.sv | 25 ++
 rtl/pcf8591_scan_ctrl_i2c_phase_gen.sv | 34 +++
 rtl/pcf8591_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pcf8591_scan_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcf8591_scan_ctrl_pkg.sv
// Shared types and protocol constants for the PCF8591 scan controller.
package pcf8591_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        WBYTE,
        WACK,
        RSTART,
        RBYTE,
        MACK,
        STOP,
        GAP
    } state_t;

    localparam logic [3:0] ADDR_PREFIX  = 4'b1001;
    localparam logic [7:0] CTRL_AUTOINC = 8'h04;
    localparam logic [7:0] CTRL_DAC_OE  = 8'h40;

    // Address byte on the wire: fixed prefix, pin-strapped bits, then R/W.
    function automatic logic [7:0] addr_byte(input logic [2:0] dev, input logic rd);
        return {ADDR_PREFIX, dev, rd};
    endfunction

endpackage

// File: rtl/pcf8591_scan_ctrl_i2c_phase_gen.sv
// SCL period timebase: free-running phase counter with drive and sample ticks.
module i2c_phase_gen #(
    parameter int SCL_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    output logic scl,
    output logic drive_tick,
    output logic sample_tick,
    output logic period_end
);

    localparam int PW = $clog2(SCL_DIV);

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (phase == PW'(SCL_DIV - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // SCL only toggles while a transfer owns the bus; it idles high otherwise.
    assign scl         = !(busy && (phase < PW'(SCL_DIV / 2)));
    assign drive_tick  = (phase == PW'(SCL_DIV / 4));
    assign sample_tick = (phase == PW'((3 * SCL_DIV) / 4));
    assign period_end  = (phase == PW'(SCL_DIV - 1));

endmodule

// File: rtl/pcf8591_scan_ctrl.sv
// PCF8591 multi-channel I2C scan master using auto-increment reads.
// Define PCF8591_DAC_EN to add the dac_val port and drive the analog output.
module pcf8591_scan_ctrl
    import pcf8591_pkg::*;
#(
    parameter int         SCL_DIV  = 100000,
    parameter logic [2:0] DEV_ADDR = 3'b000,
    parameter int         NUM_CH   = 4,
    parameter int         GAP_PER  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr_err,
`ifdef PCF8591_DAC_EN
    input  logic [7:0]          dac_val,
`endif
    output logic                scl,
    inout  wire                 sda,
    output logic [8*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                busy,
    output logic                nack_err
);

`ifdef PCF8591_DAC_EN
    localparam logic [7:0] CTRL_BYTE = CTRL_DAC_OE | CTRL_AUTOINC;
    localparam logic [2:0] LAST_WR   = 3'd2;
`else
    localparam logic [7:0] CTRL_BYTE = CTRL_AUTOINC;
    localparam logic [2:0] LAST_WR   = 3'd1;
`endif
    localparam logic [2:0] RADDR_IDX = LAST_WR + 3'd1;
    localparam logic [2:0] LAST_RD   = 3'(NUM_CH);
    localparam int         GAP_W     = (GAP_PER > 1) ? $clog2(GAP_PER) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         bit_cnt;
    logic [2:0]         byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         rx_shift;
    logic [7:0]         tx_byte;
    logic               rx_bit;
    logic               sda_low;
    logic               sda_low_nxt;
    logic               sda_in;
    logic               drive_tick;
    logic               sample_tick;
    logic               period_end;
`ifdef PCF8591_DAC_EN
    logic [7:0]         dac_lat;
`endif

    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    i2c_phase_gen #(
        .SCL_DIV(SCL_DIV)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .scl        (scl),
        .drive_tick (drive_tick),
        .sample_tick(sample_tick),
        .period_end (period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every state lasts whole SCL periods, so transitions only happen at period end.
    always_comb begin
        state_nxt = state;
        if (period_end) begin
            case (state)
                IDLE:    if (en) state_nxt = START;
                START:   state_nxt = WBYTE;
                WBYTE:   if (bit_cnt == 3'd7) state_nxt = WACK;
                WACK: begin
                    if (rx_bit)                       state_nxt = STOP;
                    else if (byte_cnt == LAST_WR)     state_nxt = RSTART;
                    else if (byte_cnt == RADDR_IDX)   state_nxt = RBYTE;
                    else                              state_nxt = WBYTE;
                end
                RSTART:  state_nxt = WBYTE;
                RBYTE:   if (bit_cnt == 3'd7) state_nxt = MACK;
                MACK:    state_nxt = (byte_cnt == LAST_RD) ? STOP : RBYTE;
                STOP:    state_nxt = GAP;
                GAP:     if (gap_cnt == GAP_W'(GAP_PER - 1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE) && (state != GAP);
        tx_byte = addr_byte(DEV_ADDR, 1'b0);
        if (byte_cnt == RADDR_IDX)  tx_byte = addr_byte(DEV_ADDR, 1'b1);
        else if (byte_cnt == 3'd1)  tx_byte = CTRL_BYTE;
`ifdef PCF8591_DAC_EN
        else if (byte_cnt == 3'd2)  tx_byte = dac_lat;
`endif
        sda_low_nxt = sda_low;
        case (state)
            START, RSTART: begin
                if (drive_tick)       sda_low_nxt = 1'b0;
                else if (sample_tick) sda_low_nxt = 1'b1;
            end
            WBYTE:       if (drive_tick) sda_low_nxt = !tx_byte[3'd7 - bit_cnt];
            WACK, RBYTE: if (drive_tick) sda_low_nxt = 1'b0;
            MACK:        if (drive_tick) sda_low_nxt = (byte_cnt != LAST_RD);
            STOP: begin
                if (drive_tick)       sda_low_nxt = 1'b1;
                else if (sample_tick) sda_low_nxt = 1'b0;
            end
            default:     sda_low_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            rx_shift <= '0;
            rx_bit   <= 1'b0;
            sda_low  <= 1'b0;
            ch_data  <= '0;
            ch_valid <= '0;
            nack_err <= 1'b0;
`ifdef PCF8591_DAC_EN
            dac_lat  <= '0;
`endif
        end else begin
            sda_low  <= sda_low_nxt;
            ch_valid <= '0;
            if (sample_tick) begin
                rx_bit <= sda_in;
                if (state == RBYTE) rx_shift <= {rx_shift[6:0], sda_in};
            end
            // Read byte 0 is the stale conversion; byte k lands in channel k-1.
            if (sample_tick && (state == RBYTE) && (bit_cnt == 3'd7)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (byte_cnt == 3'(k + 1)) begin
                        ch_data[8*k +: 8] <= {rx_shift[6:0], sda_in};
                        ch_valid[k]       <= 1'b1;
                    end
                end
            end
            if (sample_tick && (state == WACK) && sda_in) nack_err <= 1'b1;
            else if (clr_err)                            nack_err <= 1'b0;
            if (period_end) begin
                bit_cnt <= ((state == WBYTE) || (state == RBYTE)) ? bit_cnt + 3'd1 : 3'd0;
                gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
                case (state)
                    IDLE:    byte_cnt <= 3'd0;
                    WACK:    byte_cnt <= (byte_cnt == RADDR_IDX) ? 3'd0 : byte_cnt + 3'd1;
                    MACK:    byte_cnt <= byte_cnt + 3'd1;
                    default: byte_cnt <= byte_cnt;
                endcase
`ifdef PCF8591_DAC_EN
                if ((state == IDLE) && en) dac_lat <= dac_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pcf8591_scan_ctrl.sv
// Directed bench for pcf8591_scan_ctrl with a bus-level PCF8591 slave model.
module tb_pcf8591_scan_ctrl;

    localparam int         SCL_DIV  = 8;
    localparam int         NUM_CH   = 4;
    localparam int         GAP_PER  = 4;
    localparam logic [2:0] DEV_ADDR = 3'b101;
    localparam int         START_M  = 'h100;
    localparam int         STOP_M   = 'h200;
`ifdef PCF8591_DAC_EN
    localparam int EXP_LEN = 7;
    int exp_log [EXP_LEN] = '{START_M, 'h9A, 'h44, 'h80, START_M, 'h9B, STOP_M};
    logic [7:0] dac_val = 8'h80;
`else
    localparam int EXP_LEN = 6;
    int exp_log [EXP_LEN] = '{START_M, 'h9A, 'h04, START_M, 'h9B, STOP_M};
`endif
    int exp_mack [5] = '{0, 0, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr_err = 1'b0;
    logic        scl;
    wire         sda;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        busy;
    logic        nack_err;

    int errors = 0;
    int checks = 0;

    // Slave model state
    logic       slave_low = 1'b0;
    bit         s_active, s_rd, s_pend_rd, s_done, s_nack_addr;
    int         s_bitc, s_bytec;
    logic [7:0] s_sh;
    logic [7:0] s_data [5];
    int         log_q[$];
    int         mack_q[$];
    int         valid_q[$];

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    pcf8591_scan_ctrl #(
        .SCL_DIV (SCL_DIV),
        .DEV_ADDR(DEV_ADDR),
        .NUM_CH  (NUM_CH),
        .GAP_PER (GAP_PER)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr_err (clr_err),
`ifdef PCF8591_DAC_EN
        .dac_val (dac_val),
`endif
        .scl     (scl),
        .sda     (sda),
        .ch_data (ch_data),
        .ch_valid(ch_valid),
        .busy    (busy),
        .nack_err(nack_err)
    );

    always @(negedge sda) begin
        if (scl === 1'b1 && rst_n === 1'b1) begin
            s_active = 1; s_rd = 0; s_done = 0; s_bitc = 0; s_bytec = 0;
            slave_low = 1'b0;
            log_q.push_back(START_M);
        end
    end

    always @(posedge sda) begin
        if (scl === 1'b1 && s_active) begin
            s_active = 0;
            slave_low = 1'b0;
            log_q.push_back(STOP_M);
        end
    end

    always @(negedge scl) begin
        if (!s_active || s_done)
            slave_low = 1'b0;
        else if (s_bitc == 8)
            slave_low = !s_rd && !(s_nack_addr && s_bytec == 0);
        else if (s_rd && s_bytec >= 1 && s_bytec <= 5)
            slave_low = !s_data[s_bytec-1][7-s_bitc];
        else
            slave_low = 1'b0;
    end

    always @(posedge scl) begin
        if (s_active) begin
            if (s_bitc < 8) begin
                if (!s_rd) begin
                    s_sh = {s_sh[6:0], (sda === 1'b1)};
                    if (s_bitc == 7) begin
                        log_q.push_back(int'(s_sh));
                        if (s_bytec == 0) s_pend_rd = s_sh[0];
                    end
                end
                s_bitc++;
            end else begin
                if (s_rd) begin
                    mack_q.push_back((sda === 1'b1) ? 1 : 0);
                    if (sda === 1'b1) s_done = 1;
                end else if (s_bytec == 0) begin
                    s_rd = s_pend_rd;
                end
                s_bytec++;
                s_bitc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ch_valid !== 4'b0000) valid_q.push_back(int'(ch_valid));
    end

    task automatic clear_logs();
        log_q.delete();
        mack_q.delete();
        valid_q.delete();
    endtask

    task automatic wait_busy(input logic level, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === level) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_scan(output bit ok);
        bit ok1, ok2;
        en = 1'b1;
        wait_busy(1'b1, 200, ok1);
        en = 1'b0;
        wait_busy(1'b0, 3000, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        #23;
        checks++; if (scl !== 1'b1)      begin errors++; $display("[TB] FAIL reset_scl: got %b expected 1", scl); end
        checks++; if (sda !== 1'b1)      begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1 (released)", sda); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ch_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_ch_data: got %h expected 0", ch_data); end
        checks++; if (ch_valid !== 4'h0) begin errors++; $display("[TB] FAIL reset_ch_valid: got %b expected 0", ch_valid); end
        checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_nack_err: got %b expected 0", nack_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        bit ok;
        $display("[TB] test_scan");
        s_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_logs();
        run_scan(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL scan_done: busy handshake timed out, got 0 expected 1"); end
        checks++;
        if (log_q.size() != EXP_LEN) begin
            errors++; $display("[TB] FAIL scan_log_len: got %0d expected %0d", log_q.size(), EXP_LEN);
        end else begin
            for (int i = 0; i < EXP_LEN; i++) begin
                checks++;
                if (log_q[i] != exp_log[i]) begin errors++; $display("[TB] FAIL scan_log[%0d]: got %h expected %h", i, log_q[i], exp_log[i]); end
            end
        end
        checks++;
        if (mack_q.size() != 5) begin
            errors++; $display("[TB] FAIL scan_mack_len: got %0d expected 5", mack_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (mack_q[i] != exp_mack[i]) begin errors++; $display("[TB] FAIL scan_mack[%0d]: got %0d expected %0d", i, mack_q[i], exp_mack[i]); end
            end
        end
        checks++;
        if (valid_q.size() != 4) begin
            errors++; $display("[TB] FAIL scan_valid_len: got %0d expected 4", valid_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (valid_q[i] != (1 << i)) begin errors++; $display("[TB] FAIL scan_valid[%0d]: got %b expected %b", i, valid_q[i][3:0], 4'(1 << i)); end
            end
        end
        checks++; if (ch_data !== 32'h55443322) begin errors++; $display("[TB] FAIL scan_ch_data: got %h expected 55443322", ch_data); end
        checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL scan_nack_err: got %b expected 0", nack_err); end
    endtask

    task automatic test_nack();
        bit ok, seen;
        logic [31:0] prev;
        $display("[TB] test_nack");
        s_nack_addr = 1;
        s_data = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        prev = ch_data;
        clear_logs();
        run_scan(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL nack_done: busy handshake timed out, got 0 expected 1"); end
        checks++; if (nack_err !== 1'b1) begin errors++; $display("[TB] FAIL nack_flag: got %b expected 1", nack_err); end
        checks++;
        if (log_q.size() != 3) begin
            errors++; $display("[TB] FAIL nack_log_len: got %0d expected 3", log_q.size());
        end else begin
            checks++; if (log_q[1] != 'h9A)   begin errors++; $display("[TB] FAIL nack_log_addr: got %h expected 9a", log_q[1]); end
            checks++; if (log_q[2] != STOP_M) begin errors++; $display("[TB] FAIL nack_log_stop: got %h expected %h", log_q[2], STOP_M); end
        end
        checks++; if (valid_q.size() != 0) begin errors++; $display("[TB] FAIL nack_no_valid: got %0d expected 0", valid_q.size()); end
        checks++; if (ch_data !== prev) begin errors++; $display("[TB] FAIL nack_ch_data: got %h expected %h", ch_data, prev); end
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL nack_clear: got %b expected 0", nack_err); end

        // Hold clr_err through a NACK: the NACK must still register.
        clr_err = 1'b1;
        en = 1'b1;
        wait_busy(1'b1, 200, ok);
        en = 1'b0;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (nack_err === 1'b1) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL nack_beats_clr: got 0 expected 1"); end
        @(negedge clk);
        checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL nack_clr_after: got %b expected 0", nack_err); end
        clr_err = 1'b0;
        wait_busy(1'b0, 3000, ok);

        s_nack_addr = 0;
        s_data = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        clear_logs();
        run_scan(ok);
        checks++; if (ch_data !== 32'hA4A3A2A1) begin errors++; $display("[TB] FAIL nack_retry_data: got %h expected a4a3a2a1", ch_data); end
        checks++; if (valid_q.size() != 4) begin errors++; $display("[TB] FAIL nack_retry_valid: got %0d expected 4", valid_q.size()); end
    endtask

    task automatic test_reset_mid_scan();
        bit ok, seen;
        $display("[TB] test_reset_mid_scan");
        s_data = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
        clear_logs();
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (mack_q.size() >= 2) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rstmid_reach_rbyte: got 0 expected 1"); end
        repeat (4) @(negedge clk);
        #2;
        s_active = 0; s_done = 0; slave_low = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1)      begin errors++; $display("[TB] FAIL rstmid_scl: got %b expected 1", scl); end
        checks++; if (sda !== 1'b1)      begin errors++; $display("[TB] FAIL rstmid_sda: got %b expected 1 (released)", sda); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (ch_data !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_ch_data: got %h expected 0", ch_data); end
        clear_logs();
        @(negedge clk) rst_n = 1'b1;
        wait_busy(1'b1, 200, ok);
        en = 1'b0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_restart: got 0 expected 1"); end
        wait_busy(1'b0, 3000, ok);
        checks++;
        if (log_q.size() != EXP_LEN) begin
            errors++; $display("[TB] FAIL rstmid_log_len: got %0d expected %0d", log_q.size(), EXP_LEN);
        end else begin
            for (int i = 0; i < EXP_LEN; i++) begin
                checks++;
                if (log_q[i] != exp_log[i]) begin errors++; $display("[TB] FAIL rstmid_log[%0d]: got %h expected %h", i, log_q[i], exp_log[i]); end
            end
        end
        checks++; if (ch_data !== 32'h04030201) begin errors++; $display("[TB] FAIL rstmid_ch_data_after: got %h expected 04030201", ch_data); end
    endtask

    task automatic test_en_drop();
        bit ok, seen, rose;
        $display("[TB] test_en_drop");
        s_data = '{8'hFF, 8'hC0, 8'h0C, 8'h81, 8'h7E};
        clear_logs();
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (log_q.size() >= 2) begin seen = 1; break; end
        end
        repeat (2 * SCL_DIV) @(negedge clk);
        en = 1'b0;
        checks++; if (!seen) begin errors++; $display("[TB] FAIL endrop_first_byte: got 0 expected 1"); end
        wait_busy(1'b0, 3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL endrop_finish: got 0 expected 1"); end
        checks++;
        if (valid_q.size() != 4) begin
            errors++; $display("[TB] FAIL endrop_valid_len: got %0d expected 4", valid_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (valid_q[i] != (1 << i)) begin errors++; $display("[TB] FAIL endrop_valid[%0d]: got %b expected %b", i, valid_q[i][3:0], 4'(1 << i)); end
            end
        end
        checks++; if (ch_data !== 32'h7E810CC0) begin errors++; $display("[TB] FAIL endrop_ch_data: got %h expected 7e810cc0", ch_data); end
        rose = 0;
        for (int i = 0; i < 20 * SCL_DIV; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) rose = 1;
        end
        checks++; if (rose) begin errors++; $display("[TB] FAIL endrop_no_restart: got busy=1 expected busy=0"); end
        checks++; if (log_q.size() != EXP_LEN) begin errors++; $display("[TB] FAIL endrop_log_len: got %0d expected %0d", log_q.size(), EXP_LEN); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s_active = 0; s_rd = 0; s_pend_rd = 0; s_done = 0; s_nack_addr = 0;
        s_bitc = 0; s_bytec = 0; s_sh = '0;
        s_data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_scan();
        test_nack();
        test_reset_mid_scan();
        test_en_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
